demux_1to4_stream: RTL and testbench
====================================

Name: demux_1to4_stream

Overview:
- Registered 1-to-4 stream demultiplexer; the distribution side of the team's 4-to-1 selection logic.
- Accepts one input stream with valid/ready handshake and steers each accepted word to one of four output lanes (a=0, b=1, c=2, d=3).
- Lane is chosen by an explicit per-word select or by an internal round-robin pointer.
- Each lane has a one-entry holding register, so a stalled lane does not block words bound for other lanes.

Parameters:
WIDTH, 8, data word width in bits.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_data  input  WIDTH  input word.
in_sel  input  2  target lane when rr_mode=0; 0=a, 1=b, 2=c, 3=d.
rr_mode  input  1  1 = lane chosen by internal round-robin pointer; in_sel ignored.
in_valid  input  1  input word present.
in_ready  output  1  demux can accept the word currently presented.
out_data  output  4*WIDTH  lane n data at bits [n*WIDTH +: WIDTH].
out_valid  output  4  per-lane valid.
out_ready  input  4  per-lane consumer ready.
rr_ptr  output  2  current round-robin pointer (status).

Behaviour:
- Reset (rst=1 at clock edge):
  - out_valid=4'b0000, out_data=0, rr_ptr=0.
  - in_ready reflects the empty lanes in the next cycle.
  - Reset mid-operation discards all held words, with no handshake completion.
- Target lane each cycle: tgt = rr_mode ? rr_ptr : in_sel. tgt is combinational from the current inputs and state, so mode may change on any word boundary.
- in_ready = !out_valid[tgt] || out_ready[tgt].
  - The lane is empty, or draining this cycle.
  - This is a combinational path from out_ready to in_ready and is intended.
  - in_ready may depend on in_sel/rr_mode; it must not depend on in_valid.
- Input transfer: in_valid && in_ready at the clock edge.
  - out_data lane tgt <= in_data.
  - out_valid[tgt] <= 1.
- Output transfer on lane n: out_valid[n] && out_ready[n].
  - Clears out_valid[n] unless lane n is refilled in the same edge.
  - Simultaneous drain and fill of the same lane: new word loaded, out_valid stays 1 (full throughput, one word per cycle per lane).
- Latency: a word accepted at edge k appears on its lane with out_valid=1 after edge k, i.e. 1 cycle.
- out_data lane holds its value while out_valid=1 and unchanged while no new word is loaded. Data on idle lanes is don't-care but must not change except on load.
- Lanes are independent: a full, stalled lane blocks only input words targeting it.
  - Head-of-line: a blocked word stays presented; the demux never reorders or skips.
- Round-robin:
  - rr_ptr increments by 1 modulo 4 (3 wraps to 0) only on an input transfer with rr_mode=1.
  - Holds otherwise, including during stalls and explicit-mode transfers.
- No word is ever duplicated or dropped. Exactly one lane is loaded per input transfer.
- Input-side protocol rules assumed from upstream and checked by assertions in the bench: in_data, in_sel and rr_mode stable while in_valid=1 and in_ready=0.
- Outputs are registered except in_ready.

Test Plan:
- Explicit steering: rr_mode=0, all out_ready=1, send 0x11/sel0, 0x22/sel1, 0x33/sel2, 0x44/sel3 back-to-back -> in_ready=1 throughout; each word appears on lanes a,b,c,d respectively one cycle after acceptance with a single-cycle out_valid pulse.
- Stall isolation: out_ready=4'b1101 (lane b stalled); send 0xA0/sel1, 0xA1/sel1, 0xA2/sel2 ->
  - 0xA0 held on lane b; in_ready=0 while 0xA1 is presented.
  - After out_ready[1]=1 for one cycle, 0xA1 loads into lane b the same edge.
  - 0xA2 then reaches lane c; nothing lost or reordered.
- Round-robin wrap: rr_mode=1, out_ready=4'hF, send 6 words 0x01..0x06 ->
  - Lanes a,b,c,d,a,b receive them in order.
  - rr_ptr sequence is 0,1,2,3,0,1,2.
  - A 3-cycle in_valid=0 gap mid-stream leaves rr_ptr unchanged.
- Fill-while-drain: lane d full with 0x5A, out_ready[3]=1, present 0xC3/sel3 in the same cycle -> transfer occurs; next cycle out_valid[3]=1 with out_data lane d=0xC3.
- Reset mid-operation: lanes a and c full (0x77, 0x88), rr_ptr=2; assert rst one cycle -> out_valid=0, out_data=0, rr_ptr=0; the next accepted word goes to lane a in rr_mode.
- Mode switch: rr_mode=1 with rr_ptr=1; send 0x10; switch to rr_mode=0 and send 0x20/sel3; switch back to rr_mode=1 and send 0x30 -> 0x10 to lane b, 0x20 to lane d, 0x30 to lane c (pointer not advanced by the explicit-mode transfer).

Source files
------------

// File: rtl/demux_1to4_stream.sv
// rtl/demux_1to4_stream.sv - registered 1-to-4 stream demux with explicit or round-robin lane steering
module demux_1to4_stream #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               rr_mode,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [1:0]         rr_ptr
);

    logic [4*WIDTH-1:0] out_data_q, out_data_d;
    logic [3:0]         out_valid_q, out_valid_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [1:0]         tgt;
    logic               in_fire;

    assign tgt      = rr_mode ? rr_ptr_q : in_sel;
    // A lane draining this cycle can take a new word on the same edge.
    assign in_ready = !out_valid_q[tgt] || out_ready[tgt];
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q & ~out_ready;
        out_data_d  = out_data_q;
        rr_ptr_d    = rr_ptr_q;
        for (int n = 0; n < 4; n++) begin
            if (in_fire && (tgt == 2'(n))) begin
                out_valid_d[n]               = 1'b1;
                out_data_d[n*WIDTH +: WIDTH] = in_data;
            end
        end
        if (in_fire && rr_mode) begin
            rr_ptr_d = rr_ptr_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 4'b0000;
            rr_ptr_q    <= 2'd0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_demux_1to4_stream.sv
// tb/tb_demux_1to4_stream.sv - scenario tasks plus randomized queue-scoreboard run for demux_1to4_stream
module tb_demux_1to4_stream;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        rr_mode;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [1:0]  rr_ptr;

    int checks;
    int failures;

    demux_1to4_stream #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .rr_mode   (rr_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rr_ptr    (rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream must hold a blocked word unchanged.
    assert property (@(posedge clk) disable iff (rst)
        (in_valid && !in_ready) |=> ($stable(in_data) && $stable(in_sel) && $stable(rr_mode)))
        else $error("input changed while stalled");

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] lane(input int n);
        return out_data[n*8 +: 8];
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_sel = 2'd0;
        rr_mode = 1'b0; out_ready = 4'h0;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL reset_valid got=%b exp=0000", out_valid); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
        checks++; if (rr_ptr !== 2'd0) begin failures++; $display("FAIL reset_ptr got=%0d exp=0", rr_ptr); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_explicit();
        rr_mode = 1'b0; out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(8'h11 * (i + 1)); in_sel = 2'(i); in_valid = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL expl_ready%0d got=%b exp=1", i, in_ready); end
            cyc();
            checks++; if (out_valid !== 4'(1 << i)) begin failures++; $display("FAIL expl_valid%0d got=%b exp=%b", i, out_valid, 4'(1 << i)); end
            checks++; if (lane(i) !== 8'(8'h11 * (i + 1))) begin failures++; $display("FAIL expl_data%0d got=%h exp=%h", i, lane(i), 8'(8'h11 * (i + 1))); end
        end
        in_valid = 1'b0;
        cyc();
        checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL expl_drain got=%b exp=0000", out_valid); end
    endtask

    task automatic test_stall();
        rr_mode = 1'b0; out_ready = 4'b1101;
        in_data = 8'hA0; in_sel = 2'd1; in_valid = 1'b1;
        cyc();
        in_data = 8'hA1; in_sel = 2'd1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got=%b exp=0", in_ready); end
        cyc();
        checks++; if (out_valid !== 4'b0010 || lane(1) !== 8'hA0) begin failures++; $display("FAIL stall_hold got=%b/%h exp=0010/a0", out_valid, lane(1)); end
        out_ready = 4'hF;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release got=%b exp=1", in_ready); end
        cyc();
        checks++; if (out_valid !== 4'b0010 || lane(1) !== 8'hA1) begin failures++; $display("FAIL stall_refill got=%b/%h exp=0010/a1", out_valid, lane(1)); end
        out_ready = 4'b1101;
        in_data = 8'hA2; in_sel = 2'd2;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_other_ready got=%b exp=1", in_ready); end
        cyc();
        checks++; if (out_valid !== 4'b0110 || lane(2) !== 8'hA2 || lane(1) !== 8'hA1) begin
            failures++; $display("FAIL stall_other got=%b/%h/%h exp=0110/a1/a2", out_valid, lane(1), lane(2)); end
        in_valid = 1'b0; out_ready = 4'hF;
        cyc();
    endtask

    task automatic test_rr_wrap();
        rr_mode = 1'b1; out_ready = 4'hF;
        checks++; if (rr_ptr !== 2'd0) begin failures++; $display("FAIL rr_start got=%0d exp=0", rr_ptr); end
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                in_valid = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    cyc();
                    checks++; if (rr_ptr !== 2'd3) begin failures++; $display("FAIL rr_gap%0d got=%0d exp=3", g, rr_ptr); end
                end
            end
            in_data = 8'(i + 1); in_valid = 1'b1;
            #1;
            checks++; if (rr_ptr !== 2'(i % 4)) begin failures++; $display("FAIL rr_ptr%0d got=%0d exp=%0d", i, rr_ptr, i % 4); end
            cyc();
            checks++; if (out_valid !== 4'(1 << (i % 4)) || lane(i % 4) !== 8'(i + 1)) begin
                failures++; $display("FAIL rr_word%0d got=%b/%h exp=%b/%h", i, out_valid, lane(i % 4), 4'(1 << (i % 4)), 8'(i + 1)); end
        end
        checks++; if (rr_ptr !== 2'd2) begin failures++; $display("FAIL rr_end got=%0d exp=2", rr_ptr); end
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_fill_drain();
        rr_mode = 1'b0; out_ready = 4'h0;
        in_data = 8'h5A; in_sel = 2'd3; in_valid = 1'b1;
        cyc();
        checks++; if (out_valid[3] !== 1'b1 || lane(3) !== 8'h5A) begin failures++; $display("FAIL fd_load got=%b/%h exp=1/5a", out_valid[3], lane(3)); end
        out_ready = 4'b1000; in_data = 8'hC3;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fd_ready got=%b exp=1", in_ready); end
        cyc();
        checks++; if (out_valid !== 4'b1000 || lane(3) !== 8'hC3) begin failures++; $display("FAIL fd_swap got=%b/%h exp=1000/c3", out_valid, lane(3)); end
        in_valid = 1'b0; out_ready = 4'hF;
        cyc();
    endtask

    task automatic test_reset_mid();
        rr_mode = 1'b0; out_ready = 4'h0;
        in_data = 8'h77; in_sel = 2'd0; in_valid = 1'b1;
        cyc();
        in_data = 8'h88; in_sel = 2'd2;
        cyc();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 4'b0101 || rr_ptr !== 2'd2) begin failures++; $display("FAIL rmid_setup got=%b/%0d exp=0101/2", out_valid, rr_ptr); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 4'b0000 || out_data !== 32'h0 || rr_ptr !== 2'd0) begin
            failures++; $display("FAIL rmid_clear got=%b/%h/%0d exp=0000/0/0", out_valid, out_data, rr_ptr); end
        rr_mode = 1'b1; out_ready = 4'hF; in_data = 8'h99; in_valid = 1'b1;
        cyc();
        checks++; if (out_valid !== 4'b0001 || lane(0) !== 8'h99) begin failures++; $display("FAIL rmid_next got=%b/%h exp=0001/99", out_valid, lane(0)); end
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_mode_switch();
        out_ready = 4'hF;
        checks++; if (rr_ptr !== 2'd1) begin failures++; $display("FAIL ms_start got=%0d exp=1", rr_ptr); end
        rr_mode = 1'b1; in_data = 8'h10; in_valid = 1'b1;
        cyc();
        checks++; if (out_valid !== 4'b0010 || lane(1) !== 8'h10) begin failures++; $display("FAIL ms_rr1 got=%b/%h exp=0010/10", out_valid, lane(1)); end
        rr_mode = 1'b0; in_sel = 2'd3; in_data = 8'h20;
        cyc();
        checks++; if (out_valid !== 4'b1000 || lane(3) !== 8'h20 || rr_ptr !== 2'd2) begin
            failures++; $display("FAIL ms_expl got=%b/%h/%0d exp=1000/20/2", out_valid, lane(3), rr_ptr); end
        rr_mode = 1'b1; in_data = 8'h30;
        cyc();
        checks++; if (out_valid !== 4'b0100 || lane(2) !== 8'h30 || rr_ptr !== 2'd3) begin
            failures++; $display("FAIL ms_rr2 got=%b/%h/%0d exp=0100/30/3", out_valid, lane(2), rr_ptr); end
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_random();
        logic [7:0] exp_q[4][$];
        int         model_ptr;
        int         t;
        logic       exp_ready;
        logic       stalled;
        rst = 1'b1; in_valid = 1'b0;
        cyc();
        rst = 1'b0;
        model_ptr = 0;
        stalled = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!stalled) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 8'($urandom);
                in_sel   = 2'($urandom);
                rr_mode  = ($urandom_range(0, 1) == 1);
            end
            out_ready = 4'($urandom);
            #1;
            t = rr_mode ? model_ptr : int'(in_sel);
            exp_ready = (exp_q[t].size() == 0) || out_ready[t];
            checks++; if (in_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, in_ready, exp_ready); end
            checks++; if (rr_ptr !== 2'(model_ptr)) begin failures++; $display("FAIL rnd_ptr c=%0d got=%0d exp=%0d", c, rr_ptr, model_ptr); end
            for (int n = 0; n < 4; n++) begin
                checks++; if (out_valid[n] !== (exp_q[n].size() != 0)) begin
                    failures++; $display("FAIL rnd_valid c=%0d lane=%0d got=%b exp=%b", c, n, out_valid[n], exp_q[n].size() != 0); end
                if (exp_q[n].size() != 0) begin
                    checks++; if (lane(n) !== exp_q[n][0]) begin
                        failures++; $display("FAIL rnd_data c=%0d lane=%0d got=%h exp=%h", c, n, lane(n), exp_q[n][0]); end
                end
            end
            for (int n = 0; n < 4; n++) begin
                if (exp_q[n].size() != 0 && out_ready[n]) void'(exp_q[n].pop_front());
            end
            if (in_valid && exp_ready) begin
                exp_q[t].push_back(in_data);
                if (rr_mode) model_ptr = (model_ptr + 1) % 4;
            end
            stalled = in_valid && !exp_ready;
            cyc();
        end
        in_valid = 1'b0;
        cyc();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_explicit();
        test_stall();
        test_rr_wrap();
        test_fill_drain();
        test_reset_mid();
        test_mode_switch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
